ls_mem_responder: RTL and testbench

Data-memory responder for the out-of-order core. It accepts one load or store at a time from the load/store queue over the `ls_mem_bus_t` request bus and drives the single-ported data-memory interface. It waits for the memory response, then aligns and sign- or zero-extends load data. It returns the result to the ROB/CDB side on `mem_rob_data_bus_t`, and suppresses the response of a transaction that a flush has killed.

---
 rtl/ls_mem_responder_pkg.sv | 57 +++++
 rtl/ls_mem_responder_load_align.sv | 30 +++
 rtl/ls_mem_responder.sv | 134 +++++++++++++
 tb/tb_ls_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_mem_responder_pkg.sv
// Shared types for the load/store memory responder.
//   rv32i_types          : core-wide request/response bus and funct3 encodings
//   ls_mem_responder_pkg : helpers local to the responder
// No ports; packages only.
package rv32i_types;

    localparam int ROB_ID_SIZE = 3;

    typedef enum logic [1:0] {
        mem_idle      = 2'd0,
        mem_req       = 2'd1,
        mem_resp_wait = 2'd2
    } mem_controller_states;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [ROB_ID_SIZE-1:0] rob_id;
        logic [31:0]            dmem_addr;
        logic [31:0]            dmem_wdata;
        logic [3:0]             dmem_rmask;
        logic [3:0]             dmem_wmask;
        logic [2:0]             funct3;
        logic                   valid;
        logic                   flush;
    } ls_mem_bus_t;

    typedef struct packed {
        logic                   ready;
        logic [ROB_ID_SIZE-1:0] rob_id;
        logic [31:0]            rd_data;
        logic [31:0]            dmem_rdata;
        logic                   store;
    } mem_rob_data_bus_t;

endpackage

package ls_mem_responder_pkg;

    // Memory is word-addressed; byte lanes are selected by the masks.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ls_mem_responder_load_align.sv
// load_data_align: combinational load-result formatter.
//   funct3  in  3 : load type (lb/lh/lw/lbu/lhu)
//   addr_lo in  2 : byte offset within the word
//   rdata   in 32 : raw word from data memory
//   rd_data out 32: lane-selected, sign/zero-extended result
module load_data_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (load_funct3_t'(funct3))
            lb:      rd_data = {{24{byte_sel[7]}}, byte_sel};
            lbu:     rd_data = {24'h0, byte_sel};
            lh:      rd_data = {{16{half_sel[15]}}, half_sel};
            lhu:     rd_data = {16'h0, half_sel};
            default: rd_data = rdata;
        endcase
    end

endmodule

// File: rtl/ls_mem_responder.sv
// ls_mem_responder: single-outstanding data-memory controller between the
// LSQ and a single-ported data memory. Issues one access, waits for the
// memory pulse, formats load data and returns a one-cycle result to the ROB.
//   clk, rst       : clock, synchronous active-high reset
//   ls_req         : request from LSQ (ls_mem_bus_t)
//   ls_req_ready   : a request can be accepted this cycle
//   flush          : mispredict flush; kills the in-flight transaction
//   dmem_*         : data-memory request / response interface
//   mem_rob        : registered result pulse (mem_rob_data_bus_t)
module ls_mem_responder
    import rv32i_types::*;
    import ls_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ls_mem_bus_t       ls_req,
    output logic              ls_req_ready,
    input  logic              flush,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output mem_rob_data_bus_t mem_rob
);

    mem_controller_states state, state_next;

    logic [ROB_ID_SIZE-1:0] req_rob_id;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;
    logic [3:0]             req_rmask;
    logic [3:0]             req_wmask;
    logic [2:0]             req_funct3;
    logic                   killed;

    logic                   accept;
    logic                   resp_live;
    logic [31:0]            load_data;
    mem_rob_data_bus_t      rob_p1;

    load_data_align u_align (
        .funct3  (req_funct3),
        .addr_lo (req_addr[1:0]),
        .rdata   (dmem_rdata),
        .rd_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= mem_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ls_req_ready = 1'b0;
        accept       = 1'b0;
        resp_live    = 1'b0;
        dmem_rmask   = 4'h0;
        dmem_wmask   = 4'h0;
        case (state)
            mem_idle: begin
                ls_req_ready = !flush;
                accept       = ls_req.valid && !ls_req.flush && !flush;
                if (accept) begin
                    state_next = mem_req;
                end
            end
            mem_req: begin
                // A flush here cancels the access before memory ever sees it.
                if (flush) begin
                    state_next = mem_idle;
                end else begin
                    dmem_rmask = req_rmask;
                    dmem_wmask = req_wmask;
                    state_next = mem_resp_wait;
                end
            end
            mem_resp_wait: begin
                // Memory cannot be aborted: wait it out even when killed.
                if (dmem_resp) begin
                    state_next = mem_idle;
                    resp_live  = !killed && !flush;
                end
            end
            default: state_next = mem_idle;
        endcase
    end

    assign dmem_addr  = word_align(req_addr);
    assign dmem_wdata = req_wdata;

    // Request latch / kill flag / response register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            req_rob_id <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_rmask  <= '0;
            req_wmask  <= '0;
            req_funct3 <= '0;
            killed     <= 1'b0;
            rob_p1     <= '0;
        end else begin
            if (accept) begin
                req_rob_id <= ls_req.rob_id;
                req_addr   <= ls_req.dmem_addr;
                req_wdata  <= ls_req.dmem_wdata;
                req_rmask  <= ls_req.dmem_rmask;
                req_wmask  <= ls_req.dmem_wmask;
                req_funct3 <= ls_req.funct3;
                killed     <= 1'b0;
            end else if (state == mem_resp_wait && flush) begin
                killed <= 1'b1;
            end

            rob_p1 <= '0;
            if (resp_live) begin
                rob_p1.ready      <= 1'b1;
                rob_p1.rob_id     <= req_rob_id;
                rob_p1.rd_data    <= (req_wmask != 4'h0) ? 32'h0 : load_data;
                rob_p1.dmem_rdata <= dmem_rdata;
                rob_p1.store      <= (req_wmask != 4'h0);
            end
        end
    end

    assign mem_rob = rob_p1;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Testbench for ls_mem_responder: directed scenarios followed by random
// loads/stores compared against a behavioural reference model.
module tb_ls_mem_responder;
    import rv32i_types::*;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic              clk;
    logic              rst;
    ls_mem_bus_t       ls_req;
    logic              ls_req_ready;
    logic              flush;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;
    mem_rob_data_bus_t mem_rob;

    int unsigned vectors;
    int unsigned miscompares;

    ls_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ls_req       (ls_req),
        .ls_req_ready (ls_req_ready),
        .flush        (flush),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_rob      (mem_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick the addressed byte/half by shifting, extend arithmetically.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            F_LB:    return (b >= 32'd128) ? b - 32'd256 : b;
            F_LBU:   return b;
            F_LH:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            F_LHU:   return h;
            default: return w;
        endcase
    endfunction

    // One full transaction: accept at T, issue at T+1, resp at T+1+lat.
    task automatic do_txn(input logic [2:0] rob, input logic [31:0] addr, input logic [3:0] rmask,
                          input logic [3:0] wmask, input logic [31:0] wdata, input logic [2:0] f3,
                          input int lat, input logic [31:0] rdata, input bit early);
        logic [31:0] exp_rd;
        exp_rd = (wmask != 4'h0) ? 32'h0 : model_load(f3, addr[1:0], rdata);
        ls_req.rob_id     = rob;
        ls_req.dmem_addr  = addr;
        ls_req.dmem_wdata = wdata;
        ls_req.dmem_rmask = rmask;
        ls_req.dmem_wmask = wmask;
        ls_req.funct3     = f3;
        ls_req.valid      = 1'b1;
        ls_req.flush      = 1'b0;
        #1;
        chk("accept_ready", {31'h0, ls_req_ready}, 32'h1);
        tick();
        ls_req.valid = 1'b0;
        if (early) begin
            dmem_resp  = 1'b1;
            dmem_rdata = 32'hBAD0_BAD0;
        end
        #1;
        chk("issue_addr", dmem_addr, addr & ~32'h3);
        chk("issue_rmask", {28'h0, dmem_rmask}, {28'h0, rmask});
        chk("issue_wmask", {28'h0, dmem_wmask}, {28'h0, wmask});
        chk("issue_wdata", dmem_wdata, wdata);
        chk("issue_busy", {31'h0, ls_req_ready}, 32'h0);
        for (int i = 1; i < lat; i++) begin
            tick();
            dmem_resp = 1'b0;
            #1;
            chk("wait_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
            chk("wait_addr", dmem_addr, addr & ~32'h3);
            chk("wait_noresp", {31'h0, mem_rob.ready}, 32'h0);
        end
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk("resp_cycle_noready", {31'h0, mem_rob.ready}, 32'h0);
        tick();
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
        #1;
        chk("rob_ready", {31'h0, mem_rob.ready}, 32'h1);
        chk("rob_id", {29'h0, mem_rob.rob_id}, {29'h0, rob});
        chk("rob_rd_data", mem_rob.rd_data, exp_rd);
        chk("rob_raw", mem_rob.dmem_rdata, rdata);
        chk("rob_store", {31'h0, mem_rob.store}, {31'h0, (wmask != 4'h0)});
        chk("ready_after_resp", {31'h0, ls_req_ready}, 32'h1);
        tick();
        #1;
        chk("rob_pulse_end", {31'h0, mem_rob.ready}, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        ls_req      = '0;
        dmem_resp   = 1'b0;
        dmem_rdata  = 32'h0;

        // Reset values
        repeat (3) tick();
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_rob_ready", {31'h0, mem_rob.ready}, 32'h0);
        chk("rst_rob_data", mem_rob.rd_data | mem_rob.dmem_rdata, 32'h0);
        chk("rst_ready", {31'h0, ls_req_ready}, 32'h1);
        flush = 1'b1;
        #1;
        chk("rst_ready_flush", {31'h0, ls_req_ready}, 32'h0);
        flush = 1'b0;
        rst   = 1'b0;
        tick();

        // Directed loads/stores from the test plan
        do_txn(3'd5, 32'h1000_0004, 4'hF, 4'h0, 32'h0, F_LW, 3, 32'hDEAD_BEEF, 1'b0);
        do_txn(3'd1, 32'h1000_0003, 4'h8, 4'h0, 32'h0, F_LB, 2, 32'h8000_0000, 1'b0);
        do_txn(3'd2, 32'h1000_0003, 4'h8, 4'h0, 32'h0, F_LBU, 2, 32'h8000_0000, 1'b0);
        do_txn(3'd3, 32'h1000_0002, 4'hC, 4'h0, 32'h0, F_LH, 1, 32'h7FFF_1234, 1'b0);
        do_txn(3'd4, 32'h0000_0020, 4'h0, 4'hF, 32'h1234_5678, 3'b010, 2, 32'hCAFE_F00D, 1'b0);
        // A resp in the issue cycle must not be taken as the completion
        do_txn(3'd6, 32'h0000_0041, 4'h2, 4'h0, 32'h0, F_LBU, 3, 32'h0000_A500, 1'b1);

        // flush with valid request in idle: not accepted
        ls_req.valid = 1'b1; ls_req.flush = 1'b0; ls_req.dmem_rmask = 4'hF; ls_req.dmem_wmask = 4'h0;
        flush = 1'b1;
        #1;
        chk("idle_flush_ready", {31'h0, ls_req_ready}, 32'h0);
        tick();
        flush = 1'b0; ls_req.valid = 1'b0;
        #1;
        chk("idle_flush_noissue", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        // request flagged flush by the LSQ: not accepted
        ls_req.valid = 1'b1; ls_req.flush = 1'b1;
        tick();
        ls_req.valid = 1'b0; ls_req.flush = 1'b0;
        #1;
        chk("req_flush_noissue", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        // stray resp in idle
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("idle_resp_ignored", {31'h0, mem_rob.ready}, 32'h0);

        // Flush in mem_req
        ls_req.valid = 1'b1; ls_req.dmem_addr = 32'h0000_0100; ls_req.dmem_rmask = 4'hF;
        ls_req.dmem_wmask = 4'h0; ls_req.funct3 = F_LW; ls_req.rob_id = 3'd7;
        tick();
        ls_req.valid = 1'b0; flush = 1'b1;
        #1;
        chk("mreq_flush_masks", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        chk("mreq_flush_ready", {31'h0, ls_req_ready}, 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("mreq_flush_back_idle", {31'h0, ls_req_ready}, 32'h1);
        chk("mreq_flush_masks2", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("mreq_flush_noresp", {31'h0, mem_rob.ready}, 32'h0);

        // Flush in mem_resp_wait, then a new request right after dmem_resp
        ls_req.valid = 1'b1; ls_req.dmem_addr = 32'h0000_0200;
        tick();                       // issue
        ls_req.valid = 1'b0;
        tick();                       // waiting
        flush = 1'b1;
        #1;
        chk("wait_flush_ready", {31'h0, ls_req_ready}, 32'h0);
        tick();
        flush = 1'b0;
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("killed_noresp", {31'h0, mem_rob.ready}, 32'h0);
        do_txn(3'd2, 32'h0000_0302, 4'hC, 4'h0, 32'h0, F_LHU, 2, 32'h9ABC_0000, 1'b0);

        // Flush in the same cycle as dmem_resp
        ls_req.valid = 1'b1; ls_req.dmem_addr = 32'h0000_0400; ls_req.dmem_rmask = 4'hF;
        ls_req.dmem_wmask = 4'h0; ls_req.funct3 = F_LW;
        tick();
        ls_req.valid = 1'b0;
        tick();
        dmem_resp = 1'b1; flush = 1'b1;
        tick();
        dmem_resp = 1'b0; flush = 1'b0;
        #1;
        chk("flush_with_resp", {31'h0, mem_rob.ready}, 32'h0);

        // Reset in mem_resp_wait; a late resp is ignored
        ls_req.valid = 1'b1; ls_req.dmem_addr = 32'h0000_0500;
        tick();
        ls_req.valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_addr", dmem_addr, 32'h0);
        chk("midrst_ready", {31'h0, ls_req_ready}, 32'h1);
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("midrst_stray_resp", {31'h0, mem_rob.ready}, 32'h0);
        chk("midrst_no_issue", {24'h0, dmem_rmask, dmem_wmask}, 32'h0);

        // Random loads and stores
        for (int n = 0; n < 40; n++) begin
            int          k;
            logic [1:0]  off;
            logic [3:0]  m;
            logic [2:0]  f3;
            logic [31:0] a;
            k = $urandom_range(0, 7);
            off = 2'($urandom_range(0, 3));
            case (k)
                0, 1, 5: begin m = 4'b0001 << off; end
                2, 3, 6: begin off = {off[1], 1'b0}; m = 4'b0011 << off; end
                default: begin off = 2'b00; m = 4'hF; end
            endcase
            case (k)
                0: f3 = F_LB;
                1: f3 = F_LBU;
                2: f3 = F_LH;
                3: f3 = F_LHU;
                4: f3 = F_LW;
                5: f3 = 3'b000;
                6: f3 = 3'b001;
                default: f3 = 3'b010;
            endcase
            a = {$urandom} & ~32'h3;
            a = a | {30'h0, off};
            if (k >= 5)
                do_txn(3'($urandom), a, 4'h0, m, $urandom, f3, $urandom_range(1, 5), $urandom, 1'b0);
            else
                do_txn(3'($urandom), a, m, 4'h0, 32'h0, f3, $urandom_range(1, 5), $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
